// File: rtl/uart_rx_os16.sv
// 16x-oversampled 8-bit UART receiver with majority-vote bit sampling and a receive FIFO.
// Define UART_RX_PARITY_EN to expect one even-parity bit after the data bits (8E1 instead of 8N1).
module uart_rx_os16 #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic                          rd_ready,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun
);

  localparam int DIV = (CLK_HZ / (16 * BAUD) < 1) ? 1 : CLK_HZ / (16 * BAUD);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  state_t          state;
  logic [1:0]      sync;
  logic            rx_s;
  logic [DW-1:0]   div_cnt;
  logic [3:0]      tick_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            s7, s8;
  logic            tick, eval, maj;
  logic            par_bad;
  logic            push, pop, full, write;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [7:0]      mem [FIFO_DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], rx};
  end

  assign rx_s = sync[1];

  // Divider restarts on start detection so ticks 7..9 land near the middle of each bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        div_cnt <= '0;
    else if (state == IDLE && !rx_s) div_cnt <= '0;
    else if (tick)                  div_cnt <= '0;
    else                            div_cnt <= div_cnt + 1'b1;
  end

  assign tick = (div_cnt == DW'(DIV - 1));
  assign eval = tick && (tick_cnt == 4'd9);
  assign maj  = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      s7        <= 1'b1;
      s8        <= 1'b1;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (tick && state != IDLE) begin
        tick_cnt <= tick_cnt + 1'b1;
        if (tick_cnt == 4'd7) s7 <= rx_s;
        if (tick_cnt == 4'd8) s8 <= rx_s;
      end
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state    <= START;
            tick_cnt <= '0;
          end
        end
        START: begin
          if (eval) begin
            state   <= maj ? IDLE : DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (eval) begin
            shreg   <= {maj, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (eval) begin
            par_bad <= maj ^ (^shreg);
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          if (eval) begin
`ifdef UART_RX_PARITY_EN
            parity_err <= par_bad;
`endif
            if (!maj) begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end else begin
              state <= IDLE;
            end
          end
        end
        BREAK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  assign push     = eval && (state == STOP) && maj && !par_bad;
  assign rd_valid = (fifo_count != '0);
  assign pop      = rd_valid && rd_ready;
  assign full     = (fifo_count == (AW + 1)'(FIFO_DEPTH));
  assign write    = push && (!full || pop);
  assign rd_data  = rd_valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (write) mem[wr_ptr] <= shreg;
  end

  // A push into a full FIFO only succeeds when the head is popped in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overrun    <= 1'b0;
    end else begin
      overrun <= push && full && !pop;
      if (write) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({write, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Self-checking bench for uart_rx_os16: directed frames plus random bytes checked against a queue model.
// Runs with a small clock so one bit is 64 clocks at 9600 baud.
module tb_uart_rx_os16;

  localparam int CLK_HZ   = 614_400;
  localparam int BAUD     = 9600;
  localparam int DEPTH    = 16;
  localparam int DIV      = CLK_HZ / (16 * BAUD);
  localparam int BIT_CLKS = 16 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rd_ready = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [4:0] fifo_count;
  logic       frame_err, parity_err, overrun;

  uart_rx_os16 #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .fifo_count(fifo_count),
    .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int pop_cnt = 0, fe_cnt = 0, pe_cnt = 0, ov_cnt = 0;
  int exp_fe = 0, exp_pe = 0, exp_ov = 0;
  int p0;
  bit rand_ready = 1'b0;
  logic [7:0] exp_q[$];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic waitClks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rand_ready) rd_ready = 1'($urandom_range(0, 1));
    end
  endtask

  // The model decides a byte's fate from the frame's rules and the queue occupancy.
  task automatic applyStimulus(input logic [7:0] d, input bit stop_level, input int stop_bits, input bit par_ok);
    rx = 1'b0;
    waitClks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      waitClks(BIT_CLKS);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ ~par_ok;
    waitClks(BIT_CLKS);
    if (!par_ok) exp_pe++;
`endif
    if (!stop_level) exp_fe++;
    else if (par_ok) begin
      if (exp_q.size() == DEPTH) exp_ov++;
      else exp_q.push_back(d);
    end
    rx = stop_level;
    waitClks(stop_bits * BIT_CLKS);
    rx = 1'b1;
    waitClks(BIT_CLKS);
  endtask

  task automatic checkErrors(input string tag);
    checkOutput({tag, "_frame_err_pulses"}, fe_cnt, exp_fe);
    checkOutput({tag, "_parity_err_pulses"}, pe_cnt, exp_pe);
    checkOutput({tag, "_overrun_pulses"}, ov_cnt, exp_ov);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err)  fe_cnt++;
      if (parity_err) pe_cnt++;
      if (overrun)    ov_cnt++;
      if (rd_valid && rd_ready) begin
        pop_cnt++;
        if (exp_q.size() != 0) checkOutput("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_rd_valid", 32'(rd_valid), 0);
    checkOutput("reset_fifo_count", 32'(fifo_count), 0);
    checkOutput("reset_rd_data", 32'(rd_data), 0);
    checkOutput("reset_errs", {29'd0, frame_err, parity_err, overrun}, 0);
    rst = 1'b0;
    waitClks(BIT_CLKS);

    rd_ready = 1'b1;
    p0 = pop_cnt;
    applyStimulus(8'h55, 1'b1, 1, 1'b1);
    applyStimulus(8'hA3, 1'b1, 1, 1'b1);
    waitClks(8);
    checkOutput("basic_pops", pop_cnt - p0, 2);
    checkErrors("basic");

    p0 = pop_cnt;
    rx = 1'b0;
    waitClks(2 * DIV);
    rx = 1'b1;
    waitClks(3 * BIT_CLKS);
    checkOutput("glitch_fifo_count", 32'(fifo_count), 0);
    checkOutput("glitch_pops", pop_cnt - p0, 0);
    checkErrors("glitch");
    applyStimulus(8'h5A, 1'b1, 1, 1'b1);
    waitClks(8);
    checkOutput("after_glitch_pops", pop_cnt - p0, 1);

    rd_ready = 1'b0;
    applyStimulus(8'hA3, 1'b0, 20, 1'b1);
    checkOutput("ferr_fifo_count", 32'(fifo_count), 0);
    checkErrors("ferr");
    applyStimulus(8'h3C, 1'b1, 1, 1'b1);
    checkOutput("ferr_next_count", 32'(fifo_count), 1);
    checkOutput("ferr_next_data", 32'(rd_data), 32'h3C);
    rd_ready = 1'b1;
    waitClks(4);

    rd_ready = 1'b0;
    for (int i = 0; i <= 16; i++) applyStimulus(8'(i), 1'b1, 1, 1'b1);
    checkOutput("ovr_fifo_count", 32'(fifo_count), 16);
    checkOutput("ovr_head", 32'(rd_data), 0);
    checkErrors("ovr");
    p0 = pop_cnt;
    rd_ready = 1'b1;
    waitClks(40);
    checkOutput("ovr_drain_pops", pop_cnt - p0, 16);
    checkOutput("ovr_drain_count", 32'(fifo_count), 0);

    rd_ready = 1'b0;
    applyStimulus(8'h11, 1'b1, 1, 1'b1);
    rx = 1'b0;
    waitClks(BIT_CLKS);
    rx = 1'b1;
    waitClks(4 * BIT_CLKS + BIT_CLKS / 2);
    rst = 1'b1;
    waitClks(3);
    checkOutput("rst_rd_valid", 32'(rd_valid), 0);
    checkOutput("rst_fifo_count", 32'(fifo_count), 0);
    checkOutput("rst_rd_data", 32'(rd_data), 0);
    checkOutput("rst_errs", {29'd0, frame_err, parity_err, overrun}, 0);
    exp_q.delete();
    rst = 1'b0;
    waitClks(BIT_CLKS / 2 + 5 * BIT_CLKS);
    checkOutput("rst_no_push", 32'(fifo_count), 0);
    checkErrors("rst");
    p0 = pop_cnt;
    rd_ready = 1'b1;
    applyStimulus(8'h81, 1'b1, 1, 1'b1);
    waitClks(8);
    checkOutput("rst_next_pops", pop_cnt - p0, 1);

`ifdef UART_RX_PARITY_EN
    p0 = pop_cnt;
    applyStimulus(8'h07, 1'b1, 1, 1'b0);
    checkOutput("par_bad_count", 32'(fifo_count), 0);
    checkErrors("par_bad");
    applyStimulus(8'h07, 1'b1, 1, 1'b1);
    waitClks(8);
    checkOutput("par_ok_pops", pop_cnt - p0, 1);
    checkErrors("par_ok");
`endif

    p0 = pop_cnt;
    rand_ready = 1'b1;
    for (int i = 0; i < 10; i++) applyStimulus(8'($urandom_range(0, 255)), 1'b1, 1, 1'b1);
    rand_ready = 1'b0;
    rd_ready = 1'b1;
    waitClks(8);
    checkOutput("rand_pops", pop_cnt - p0, 10);
    checkOutput("rand_fifo_count", 32'(fifo_count), 0);
    checkErrors("rand");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
